// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, helpers and status typedef for fifo_level
package fifo_pkg;

  localparam int DEF_AWIDTH   = 4;
  localparam int DEF_DWIDTH   = 8;
  localparam int DEF_AE_LEVEL = 2;

  // Pointers carry one extra wrap bit beyond the address.
  function automatic int ptr_width(input int awidth);
    return awidth + 1;
  endfunction

  function automatic int def_af_level(input int awidth);
    return (2 ** awidth) - 2;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_level_if.sv
// rtl/fifo_level_if.sv - write/read/status bundle between a client and fifo_level
interface fifo_level_if
  import fifo_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) ();

  logic              flush;
  logic              wr_en;
  logic [DWIDTH-1:0] data_in;
  logic              rd_en;
  logic [DWIDTH-1:0] data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [AWIDTH:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DWIDTH register array, synchronous write, asynchronous read
module fifo_mem #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  // Storage is deliberately left unreset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_level.sv
// rtl/fifo_level.sv - synchronous FIFO with count, thresholds, sticky errors, flush (option: FIFO_FWFT_EN)
module fifo_level
  import fifo_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int AF_LEVEL = def_af_level(AWIDTH),
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input logic         clk,
  input logic         rst_n,
  fifo_level_if.slave bus
);

  localparam int              PTR_W = ptr_width(AWIDTH);
  localparam logic [AWIDTH:0] AF_L  = PTR_W'(AF_LEVEL);
  localparam logic [AWIDTH:0] AE_L  = PTR_W'(AE_LEVEL);

  logic [AWIDTH:0]   wptr, rptr, count;
  logic              wr_ok, rd_ok;
  logic              overflow_q, underflow_q;
  logic [DWIDTH-1:0] mem_rdata;
  fifo_status_t      status;

  assign count = wptr - rptr;

  // Full/empty come from the wrap bit and address bits, never from a last-op flag.
  assign status.empty        = (wptr == rptr);
  assign status.full         = (wptr[AWIDTH] != rptr[AWIDTH]) &&
                               (wptr[AWIDTH-1:0] == rptr[AWIDTH-1:0]);
  assign status.almost_full  = (count >= AF_L);
  assign status.almost_empty = (count <= AE_L);

  // A read frees a slot in the same cycle, so a full FIFO can accept a write alongside it.
  assign rd_ok = bus.rd_en & ~status.empty;
  assign wr_ok = bus.wr_en & (~status.full | rd_ok);

  fifo_mem #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok & ~bus.flush),
    .waddr(wptr[AWIDTH-1:0]),
    .wdata(bus.data_in),
    .raddr(rptr[AWIDTH-1:0]),
    .rdata(mem_rdata)
  );

  // Pointer and sticky error flag state; flush overrides any request in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wptr        <= '0;
      rptr        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_W'(1);
      if (rd_ok) rptr <= rptr + PTR_W'(1);
      if (bus.wr_en && !wr_ok) overflow_q  <= 1'b1;
      if (bus.rd_en && !rd_ok) underflow_q <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; rd_en acknowledges and pops it.
  assign bus.data_out = mem_rdata;
  assign bus.rd_valid = ~status.empty;
`else
  logic [DWIDTH-1:0] data_q;
  logic              rd_valid_q;

  // Registered read path: popped word appears one cycle after rd_ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
    end else if (bus.flush) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) data_q <= mem_rdata;
    end
  end

  assign bus.data_out = data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = status.full;
  assign bus.empty        = status.empty;
  assign bus.almost_full  = status.almost_full;
  assign bus.almost_empty = status.almost_empty;
  assign bus.count        = count;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_level.sv
// tb/tb_fifo_level.sv - directed self-checking bench for fifo_level (DEPTH=4, AF=3, AE=1)
module tb_fifo_level;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fifo_level_if #(.AWIDTH(2), .DWIDTH(8)) bus ();

  fifo_level #(
    .AWIDTH  (2),
    .DWIDTH  (8),
    .AF_LEVEL(3),
    .AE_LEVEL(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_empty"}, 32'(bus.empty), 1);
    chk({tag, "_ae"}, 32'(bus.almost_empty), 1);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_af"}, 32'(bus.almost_full), 0);
    chk({tag, "_rdv"}, 32'(bus.rd_valid), 0);
    chk({tag, "_dout"}, 32'(bus.data_out), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow), 0);
    chk({tag, "_udf"}, 32'(bus.underflow), 0);
  endtask

  initial begin
    logic [7:0] exp_q [4];

    rst_n       = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    rst_n = 1'b1;
    tick();

    // Fill to full: thresholds at count 1 (AE) and 3 (AF)
    for (int i = 1; i <= 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.data_in = 8'hA0 + 8'(i);
      tick();
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_af", 32'(bus.almost_full), 32'(i >= 3));
      chk("fill_ae", 32'(bus.almost_empty), 32'(i <= 1));
      chk("fill_full", 32'(bus.full), 32'(i == 4));
      chk("fill_empty", 32'(bus.empty), 0);
    end
    chk("fill_ovf", 32'(bus.overflow), 0);

    // Write into full FIFO is dropped, overflow sticks
    bus.data_in = 8'h55;
    tick();
    bus.wr_en = 1'b0;
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 4);
    tick();
    chk("ovf_sticky", 32'(bus.overflow), 1);

    // Drain with idle gaps: rd_valid only on the cycle after each rd_en
    for (int i = 1; i <= 4; i++) begin
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("drain_rdv", 32'(bus.rd_valid), 1);
      chk("drain_data", 32'(bus.data_out), 32'(8'hA0 + 8'(i)));
      chk("drain_count", 32'(bus.count), 32'(4 - i));
      tick();
      chk("drain_idle_rdv", 32'(bus.rd_valid), 0);
    end
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_ovf_kept", 32'(bus.overflow), 1);

    // Refill, then simultaneous write+read on full
    bus.wr_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.data_in = 8'hA0 + 8'(i);
      tick();
    end
    chk("refill_full", 32'(bus.full), 1);
    bus.rd_en   = 1'b1;
    bus.data_in = 8'h77;
    tick();
    bus.wr_en = 1'b0;
    chk("both_full_count", 32'(bus.count), 4);
    chk("both_full_rdv", 32'(bus.rd_valid), 1);
    chk("both_full_data", 32'(bus.data_out), 32'h A1);
    exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'h77};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("both_drain_rdv", 32'(bus.rd_valid), 1);
      chk("both_drain_data", 32'(bus.data_out), 32'(exp_q[k]));
    end
    chk("both_drain_count", 32'(bus.count), 0);

    // Read of empty FIFO is refused
    tick();
    chk("udf_set", 32'(bus.underflow), 1);
    chk("udf_rdv", 32'(bus.rd_valid), 0);
    chk("udf_count", 32'(bus.count), 0);
    bus.wr_en   = 1'b1;
    bus.data_in = 8'h3C;
    tick();
    bus.wr_en = 1'b0;
    chk("empty_both_count", 32'(bus.count), 1);
    chk("empty_both_rdv", 32'(bus.rd_valid), 0);
    tick();
    bus.rd_en = 1'b0;
    chk("empty_both_data", 32'(bus.data_out), 32'h3C);
    chk("empty_both_rdv2", 32'(bus.rd_valid), 1);
    chk("empty_both_count2", 32'(bus.count), 0);

    // Ten write/read pairs carry both pointers past their wrap
    for (int i = 0; i < 10; i++) begin
      bus.wr_en   = 1'b1;
      bus.data_in = 8'h10 + 8'(i);
      tick();
      bus.wr_en = 1'b0;
      chk("wrap_count1", 32'(bus.count), 1);
      chk("wrap_full", 32'(bus.full), 0);
      chk("wrap_empty1", 32'(bus.empty), 0);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("wrap_data", 32'(bus.data_out), 32'(8'h10 + 8'(i)));
      chk("wrap_rdv", 32'(bus.rd_valid), 1);
      chk("wrap_count0", 32'(bus.count), 0);
      chk("wrap_empty0", 32'(bus.empty), 1);
    end

    // Flush beats a simultaneous write
    bus.wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_in = 8'hC0 + 8'(i);
      tick();
    end
    chk("pre_flush_count", 32'(bus.count), 3);
    chk("pre_flush_ovf", 32'(bus.overflow), 1);
    bus.flush   = 1'b1;
    bus.data_in = 8'hEE;
    tick();
    bus.flush = 1'b0;
    bus.wr_en = 1'b0;
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_empty", 32'(bus.empty), 1);
    chk("flush_ovf", 32'(bus.overflow), 0);
    chk("flush_udf", 32'(bus.underflow), 0);
    chk("flush_rdv", 32'(bus.rd_valid), 0);

    // Reset during a read: rd_valid drops without waiting for a clock
    bus.wr_en   = 1'b1;
    bus.data_in = 8'h99;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    chk("pre_rst_rdv", 32'(bus.rd_valid), 1);
    chk("pre_rst_data", 32'(bus.data_out), 32'h99);
    #2;
    rst_n = 1'b0;
    #1;
    bus.rd_en = 1'b0;
    chk_reset_state("midrst");
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
Name: fifo_level

Overview:
Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush and an explicit read-valid strobe.
- Intended as the standard buffering element between streaming datapath stages in one clock domain.
- Full/empty are derived from extended pointers, not from a last-operation bit.

Parameters:
AWIDTH, 4, address width; DEPTH = 2**AWIDTH entries (AWIDTH >= 1)
DWIDTH, 8, data word width in bits
AF_LEVEL, 2**AWIDTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  rising-edge clock, sole clock domain
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of pointers, count and error flags
wr_en  input  1  write request
data_in  input  DWIDTH  write data
rd_en  input  1  read (pop) request
data_out  output  DWIDTH  read data
rd_valid  output  1  data_out holds a popped/head word this cycle
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  AWIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a read was refused

Behaviour:
- Reset: asynchronous, active-low; clk single domain; while rst_n=0: wptr=rptr=0, count=0, data_out=0, rd_valid=0, overflow=underflow=0; empty=1, almost_empty=1, full=0, almost_full=0. Memory contents not reset.
- Pointers: wptr, rptr are AWIDTH+1 bits; address = low AWIDTH bits; wrap modulo 2*DEPTH.
  - full when MSBs differ and low bits equal; empty when the pointers are equal.
  - count = wptr - rptr (AWIDTH+1-bit unsigned subtract).
- Acceptance per cycle:
  - wr_ok = wr_en & (!full | rd_ok)
  - rd_ok = rd_en & !empty
  - Full with both requests: both accepted, count unchanged.
  - Empty with both requests: write accepted, read refused.
- Write: on wr_ok, memory[wptr] <= data_in, wptr+1.
- Read: on rd_ok, rptr+1. Default data path is registered: data_out <= memory[rptr] and rd_valid=1 on the cycle after rd_ok (1-cycle latency); otherwise rd_valid=0 and data_out holds its last value.
- Error flags:
  - overflow sets on wr_en & !wr_ok.
  - underflow sets on rd_en & !rd_ok.
  - Both are sticky until rst_n or flush.
- Flush: flush=1 at a clock edge sets pointers, count and error flags to reset values, and rd_valid=0 next cycle. Flush has priority over wr_en/rd_en in the same cycle (both are ignored and no error flag is set). data_out holds.
- All status outputs (full, empty, almost_*, count) are combinational from the registered pointers and update the cycle after the accepted operation.
- Reset mid-operation: any in-flight read is discarded and rd_valid drops immediately.

Optional Feature:
FIFO_FWFT_EN:
- Defined: first-word-fall-through mode.
  - data_out = memory[rptr] (combinational from the head), rd_valid = !empty.
  - rd_en acts as an acknowledge: it pops the word currently on data_out, with zero read latency.
  - Reset/flush give rd_valid=0; data_out is don't-care while empty.
- Undefined: registered 1-cycle-latency read path as described above.

Decomposition:
- Package fifo_pkg: pointer-width helper constant (AWIDTH+1), the default threshold values, and the status-bundle typedef {full, empty, almost_full, almost_empty}.
- One natural sub-module: fifo_mem, a DEPTH x DWIDTH dual-port register array with synchronous write and asynchronous read; the top instantiates it and keeps all control logic.

Test Plan (AWIDTH=2, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1):
- Reset then write 0xA1,0xA2,0xA3,0xA4 on consecutive cycles -> count 1,2,3,4; almost_full at count 3; full=1 after the 4th write; overflow=0.
- Full FIFO, wr_en=1 with data 0x55, rd_en=0 -> write dropped, overflow=1 and stays set; count=4; subsequent reads return 0xA1..0xA4 with rd_valid one cycle after each rd_en.
- Full FIFO, wr_en=rd_en=1 with data 0x77 for 1 cycle -> count stays 4; read returns 0xA1; the last read, after draining, returns 0x77.
- Empty FIFO, rd_en=1 -> underflow=1, rd_valid=0, count=0; empty FIFO with rd_en=wr_en=1 -> write accepted, count=1, read refused.
- 10 write/read pairs (pointer wrap past 2*DEPTH) -> data order preserved, empty/full never glitch, count returns to 0.
- Count=3 with overflow set, pulse flush with wr_en=1 -> count=0, empty=1, overflow=0, nothing written; then assert rst_n=0 mid-read -> rd_valid=0 immediately and all outputs at reset values.
